// File: rtl/rgb_seq_pkg.sv
// Shared types and helpers for the RGB colour-wheel sequencer.
// gamma_sq is the square-law duty curve selected by RGB_GAMMA_EN in the top level.
package rgb_seq_pkg;

  localparam int NUM_SECTORS = 6;

  typedef enum logic [2:0] {
    SEC_R_Y = 3'd0,
    SEC_Y_G = 3'd1,
    SEC_G_C = 3'd2,
    SEC_C_B = 3'd3,
    SEC_B_M = 3'd4,
    SEC_M_R = 3'd5
  } sector_t;

  // ((d+1)^2 - 1) >> w keeps 0 at 0 and full scale at full scale for any width w <= 16.
  function automatic logic [15:0] gamma_sq(input logic [15:0] d, input int unsigned w);
    logic [31:0] w_d1;
    logic [31:0] w_sq;
    w_d1 = {16'd0, d} + 32'd1;
    w_sq = (w_d1 * w_d1) - 32'd1;
    return w_sq[15 + w -: 16];
  endfunction

endpackage

// File: rtl/hue_prescaler.sv
// Ramp-step prescaler: counts enabled clocks and emits one tick every TICK_DIV of them.
// A clear forces the count back to zero and suppresses the tick for that cycle.
module hue_prescaler #(
  parameter int TICK_DIV = 7843
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CNT_LAST);
  assign tick   = en & w_last & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/hue_wheel_sequencer.sv
// Six-sector HSV colour wheel producing registered R/G/B PWM duty words.
// Define RGB_GAMMA_EN to apply the square-law curve ahead of the output registers.
module hue_wheel_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int DUTY_W   = 8,
  parameter int TICK_DIV = 7843
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic [2:0]        sector,
  output logic              upd,
  output logic              wrap
);

  localparam logic [DUTY_W-1:0] RAMP_MAX = '1;
  localparam logic [DUTY_W-1:0] RAMP_ONE = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] RAMP_TOP = RAMP_MAX - RAMP_ONE;

  logic              w_tick;
  logic [DUTY_W-1:0] r_ramp;
  logic [DUTY_W-1:0] w_ramp_next;
  sector_t           r_sector;
  sector_t           w_sector_next;
  logic              r_upd;
  logic              w_upd_next;
  logic              r_wrap;
  logic              w_wrap_next;
  logic [DUTY_W-1:0] w_up;
  logic [DUTY_W-1:0] w_dn;
  logic [DUTY_W-1:0] w_lin [3];

  hue_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (restart),
    .tick(w_tick)
  );

  // restart outranks the tick and is honoured whether or not en is high
  always_comb begin
    w_ramp_next   = r_ramp;
    w_sector_next = r_sector;
    w_upd_next    = 1'b0;
    w_wrap_next   = 1'b0;
    if (restart) begin
      w_ramp_next   = '0;
      w_sector_next = SEC_R_Y;
      w_upd_next    = 1'b1;
    end else if (w_tick) begin
      w_upd_next = 1'b1;
      if (r_ramp == RAMP_TOP) begin
        w_ramp_next = '0;
        case (r_sector)
          SEC_R_Y: w_sector_next = SEC_Y_G;
          SEC_Y_G: w_sector_next = SEC_G_C;
          SEC_G_C: w_sector_next = SEC_C_B;
          SEC_C_B: w_sector_next = SEC_B_M;
          SEC_B_M: w_sector_next = SEC_M_R;
          SEC_M_R: begin
            w_sector_next = SEC_R_Y;
            w_wrap_next   = 1'b1;
          end
          default: w_sector_next = SEC_R_Y;
        endcase
      end else begin
        w_ramp_next = r_ramp + RAMP_ONE;
      end
    end
    case (r_sector)
      SEC_R_Y, SEC_Y_G, SEC_G_C, SEC_C_B, SEC_B_M, SEC_M_R: ;
      default: begin
        w_sector_next = SEC_R_Y;
        w_ramp_next   = '0;
      end
    endcase
  end

  // Duty map is driven from the next state so the output words line up with ramp/sector.
  always_comb begin
    w_up     = w_ramp_next;
    w_dn     = RAMP_MAX - w_ramp_next;
    w_lin[0] = RAMP_MAX;
    w_lin[1] = '0;
    w_lin[2] = '0;
    case (w_sector_next)
      SEC_R_Y: begin w_lin[0] = RAMP_MAX; w_lin[1] = w_up;     w_lin[2] = '0;       end
      SEC_Y_G: begin w_lin[0] = w_dn;     w_lin[1] = RAMP_MAX; w_lin[2] = '0;       end
      SEC_G_C: begin w_lin[0] = '0;       w_lin[1] = RAMP_MAX; w_lin[2] = w_up;     end
      SEC_C_B: begin w_lin[0] = '0;       w_lin[1] = w_dn;     w_lin[2] = RAMP_MAX; end
      SEC_B_M: begin w_lin[0] = w_up;     w_lin[1] = '0;       w_lin[2] = RAMP_MAX; end
      SEC_M_R: begin w_lin[0] = RAMP_MAX; w_lin[1] = '0;       w_lin[2] = w_dn;     end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ramp   <= '0;
      r_sector <= SEC_R_Y;
      r_upd    <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_ramp   <= w_ramp_next;
      r_sector <= w_sector_next;
      r_upd    <= w_upd_next;
      r_wrap   <= w_wrap_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      localparam logic [DUTY_W-1:0] DUTY_RST = (gi == 0) ? RAMP_MAX : '0;
      logic [DUTY_W-1:0] w_duty_next;
      logic [DUTY_W-1:0] r_duty;
`ifdef RGB_GAMMA_EN
      assign w_duty_next = DUTY_W'(gamma_sq(16'(w_lin[gi]), DUTY_W));
`else
      assign w_duty_next = w_lin[gi];
`endif
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_duty <= DUTY_RST;
        end else begin
          r_duty <= w_duty_next;
        end
      end
    end
  endgenerate

  assign duty_r = g_ch[0].r_duty;
  assign duty_g = g_ch[1].r_duty;
  assign duty_b = g_ch[2].r_duty;
  assign sector = r_sector;
  assign upd    = r_upd;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_hue_wheel_sequencer.sv
// Bench for hue_wheel_sequencer (DUTY_W=3, TICK_DIV=4): directed steps then random en/restart,
// checked against a wheel-position model; build with RGB_GAMMA_EN to check the gamma variant.
module tb_hue_wheel_sequencer;

  localparam int DW    = 3;
  localparam int TD    = 4;
  localparam int M     = 7;
  localparam int STEPS = 6 * M;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          restart;
  logic [DW-1:0] duty_r;
  logic [DW-1:0] duty_g;
  logic [DW-1:0] duty_b;
  logic [2:0]    sector;
  logic          upd;
  logic          wrap;

  int vectors     = 0;
  int miscompares = 0;

  // Model: position on the wheel (0..41), enabled clocks since last step, and the pulses.
  int m_pos;
  int m_pc;
  bit m_upd;
  bit m_wrap;
  int wrap_seen;

  always #5 clk = ~clk;

  hue_wheel_sequencer #(
    .DUTY_W  (DW),
    .TICK_DIV(TD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(restart),
    .duty_r (duty_r),
    .duty_g (duty_g),
    .duty_b (duty_b),
    .sector (sector),
    .upd    (upd),
    .wrap   (wrap)
  );

  function automatic int gam(input int d);
`ifdef RGB_GAMMA_EN
    return ((d + 1) * (d + 1) - 1) >> DW;
`else
    return d;
`endif
  endfunction

  // Hue wheel: each sector holds one channel at full, one at zero, and ramps the third.
  function automatic int exp_duty(input int pos, input int ch);
    int s, up, dn;
    int rgb [3];
    s  = pos / M;
    up = pos % M;
    dn = M - up;
    case (s)
      0: rgb = '{M, up, 0};
      1: rgb = '{dn, M, 0};
      2: rgb = '{0, M, up};
      3: rgb = '{0, dn, M};
      4: rgb = '{up, 0, M};
      default: rgb = '{M, 0, dn};
    endcase
    return gam(rgb[ch]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_r"},      duty_r, exp_duty(m_pos, 0));
    check({tag, "_g"},      duty_g, exp_duty(m_pos, 1));
    check({tag, "_b"},      duty_b, exp_duty(m_pos, 2));
    check({tag, "_sector"}, sector, m_pos / M);
    check({tag, "_upd"},    upd,    m_upd);
    check({tag, "_wrap"},   wrap,   m_wrap);
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_pc   = 0;
    m_upd  = 1'b0;
    m_wrap = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit rs);
    m_upd  = 1'b0;
    m_wrap = 1'b0;
    if (rs) begin
      m_pos = 0;
      m_pc  = 0;
      m_upd = 1'b1;
    end else if (e) begin
      if (m_pc == TD - 1) begin
        m_pc   = 0;
        m_pos  = (m_pos + 1) % STEPS;
        m_upd  = 1'b1;
        m_wrap = (m_pos == 0);
      end else begin
        m_pc++;
      end
    end
  endtask

  task automatic cycle(input bit e, input bit rs, input string tag);
    en      = e;
    restart = rs;
    @(posedge clk);
    model_edge(e, rs);
    @(negedge clk);
    if (wrap === 1'b1) wrap_seen++;
    check_all(tag);
  endtask

  task automatic advance_to(input int pos, input int pc, input string tag);
    int g;
    g = 0;
    while (!(m_pos == pos && m_pc == pc) && g < 500) begin
      cycle(1'b1, 1'b0, tag);
      g++;
    end
    if (g >= 500) timeout(tag);
  endtask

  initial begin
    int held_pc;
    int k;
    bit e;
    bit rs;

    // 1. reset state
    rst     = 1'b1;
    en      = 1'b0;
    restart = 1'b0;
    model_reset();
    wrap_seen = 0;
    #12;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("step reset done");

    // 2. first tick on the 4th enabled clock
    for (int i = 0; i < TD - 1; i++) cycle(1'b1, 1'b0, "pre_tick");
    cycle(1'b1, 1'b0, "first_tick");
    check("first_tick_g",   duty_g, gam(1));
    check("first_tick_upd", upd, 1'b1);
    cycle(1'b1, 1'b0, "after_tick");
    check("after_tick_upd", upd, 1'b0);
    $display("step first tick done");

    // 3. full wheel: 168 enabled clocks since reset
    wrap_seen = 0;
    for (int i = 0; i < 6 * M * TD - TD - 1; i++) begin
      cycle(1'b1, 1'b0, "wheel");
      if (m_pos == M && m_upd) begin
        check("sector1_entry_r", duty_r, gam(M));
        check("sector1_entry_g", duty_g, gam(M));
        check("sector1_entry_b", duty_b, 0);
      end
    end
    check("wheel_wrap_count", wrap_seen, 1);
    check("wheel_end_r",      duty_r, gam(M));
    check("wheel_end_g",      duty_g, 0);
    check("wheel_end_sector", sector, 0);
    $display("step full wheel done");

    // gamma / linear point: sector 0, ramp 4
    advance_to(4, 0, "to_ramp4");
`ifdef RGB_GAMMA_EN
    check("ramp4_g", duty_g, 3);
`else
    check("ramp4_g", duty_g, 4);
`endif

    // 4. freeze at sector 2 ramp 3, mid-prescaler
    advance_to(2 * M + 3, 1, "to_freeze");
    held_pc = m_pc;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, "freeze");
      check("freeze_r", duty_r, exp_duty(2 * M + 3, 0));
    end
    k = 0;
    do begin
      cycle(1'b1, 1'b0, "resume");
      k++;
    end while (upd !== 1'b1 && k < 10);
    check("resume_latency", k, TD - held_pc);
    $display("step freeze done");

    // 5. restart coinciding with a tick in sector 3, then with en low
    advance_to(3 * M + 2, TD - 1, "to_restart1");
    cycle(1'b1, 1'b1, "restart_en");
    check("restart_en_sector", sector, 0);
    check("restart_en_upd",    upd, 1'b1);
    check("restart_en_r",      duty_r, gam(M));
    advance_to(3 * M + 2, TD - 1, "to_restart2");
    cycle(1'b0, 1'b1, "restart_noen");
    check("restart_noen_sector", sector, 0);
    check("restart_noen_upd",    upd, 1'b1);
    check("restart_noen_wrap",   wrap, 1'b0);
    $display("step restart done");

    // 6. asynchronous reset in sector 4, between edges
    advance_to(4 * M + 2, 2, "to_async");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    $display("step async reset done");

    // random en / restart traffic
    for (int i = 0; i < 600; i++) begin
      e  = ($urandom_range(0, 9) < 8);
      rs = ($urandom_range(0, 59) == 0);
      cycle(e, rs, "random");
    end
    $display("step random done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
